// File: rtl/pipe_stage_reg_if.sv
// Stage-boundary bus: upstream valid/ready/ctrl/data in, downstream valid/ready/ctrl/data out.
// master = the pipeline register; slave = the neighbouring stage logic.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 32,
  parameter int DATA_W = 160
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid entry,
// flush-to-bubble and a saturating stall counter.
module pipe_stage_reg #(
  parameter int CTRL_W   = 32,
  parameter int DATA_W   = 160,
  parameter int SKID     = 1,
  parameter int CLR_DATA = 0,
  parameter int STALL_W  = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               flush,
  pipe_stage_reg_if.master   bus,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t              r_state, w_state_nxt;
  logic [CTRL_W-1:0]   r_main_ctrl, r_skid_ctrl;
  logic [DATA_W-1:0]   r_main_data, r_skid_data;
  logic [STALL_W-1:0]  r_stall;
  logic                w_accept, w_drain, w_out_valid, w_in_ready;
  logic                w_main_ld_in, w_main_ld_skid, w_main_clr, w_skid_ld, w_skid_clr;

  assign w_out_valid = (r_state != EMPTY);

  // With a skid entry, ready depends only on state flops, cutting the out_ready -> in_ready path.
  generate
    if (SKID != 0) begin : g_skid
      assign w_in_ready = (r_state != TWO);
    end else begin : g_noskid
      assign w_in_ready = !w_out_valid || bus.out_ready;
    end
  endgenerate

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_drain  = w_out_valid && bus.out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_main_clr     = 1'b0;
    w_skid_ld      = 1'b0;
    w_skid_clr     = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_clr  = 1'b1;
      w_skid_clr  = 1'b1;
    end else begin
      case (r_state)
        EMPTY: if (w_accept) begin
          w_main_ld_in = 1'b1;
          w_state_nxt  = ONE;
        end
        ONE: begin
          if (w_accept && w_drain) begin
            w_main_ld_in = 1'b1;
          end else if (w_accept && (SKID != 0)) begin
            w_skid_ld   = 1'b1;
            w_state_nxt = TWO;
          end else if (w_drain) begin
            w_main_clr  = 1'b1;
            w_state_nxt = EMPTY;
          end
        end
        TWO: if (w_drain) begin
          w_main_ld_skid = 1'b1;
          w_skid_clr     = 1'b1;
          w_state_nxt    = ONE;
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Emptying main always writes a NOP control word so downstream sees a clean bubble.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
    end else if (w_main_clr) begin
      r_main_ctrl <= '0;
      if (CLR_DATA != 0) r_main_data <= '0;
    end else if (w_main_ld_in) begin
      r_main_ctrl <= bus.in_ctrl;
      r_main_data <= bus.in_data;
    end else if (w_main_ld_skid) begin
      r_main_ctrl <= r_skid_ctrl;
      r_main_data <= r_skid_data;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (w_skid_clr) begin
      r_skid_ctrl <= '0;
      if (CLR_DATA != 0) r_skid_data <= '0;
    end else if (w_skid_ld) begin
      r_skid_ctrl <= bus.in_ctrl;
      r_skid_data <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr)                                                r_stall <= '0;
    else if (w_out_valid && !bus.out_ready && r_stall != '1) r_stall <= r_stall + STALL_W'(1);
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_ctrl  = r_main_ctrl;
  assign bus.out_data  = r_main_data;
  assign stall_cnt     = r_stall;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: dut1 = SKID=1/CLR_DATA=0/STALL_W=16, dut0 = SKID=0/CLR_DATA=1/STALL_W=4.
module tb_pipe_stage_reg;
  logic clk, clr, flush1, flush0;
  logic [15:0] stall1;
  logic [3:0]  stall0;
  int n_chk, n_pass;
  logic [63:0] q1[$], q0[$];
  logic [63:0] e1, e0;

  pipe_stage_reg_if #(.CTRL_W(32), .DATA_W(32)) if1 ();
  pipe_stage_reg_if #(.CTRL_W(32), .DATA_W(32)) if0 ();

  pipe_stage_reg #(.CTRL_W(32), .DATA_W(32), .SKID(1), .CLR_DATA(0), .STALL_W(16)) dut1 (
    .clk(clk), .clr(clr), .flush(flush1), .bus(if1.master), .stall_cnt(stall1));
  pipe_stage_reg #(.CTRL_W(32), .DATA_W(32), .SKID(0), .CLR_DATA(1), .STALL_W(4)) dut0 (
    .clk(clk), .clr(clr), .flush(flush0), .bus(if0.master), .stall_cnt(stall0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboards: push on accept, pop/compare on drain, drop held entries on flush/clr.
  always @(negedge clk) begin
    if (clr) q1.delete();
    else begin
      if (if1.out_valid && if1.out_ready) begin
        n_chk++;
        if (q1.size() == 0) $display("FAIL sb1_unexpected got=%h_%h", if1.out_ctrl, if1.out_data);
        else begin
          e1 = q1.pop_front();
          if ({if1.out_ctrl, if1.out_data} !== e1) $display("FAIL sb1_order got=%h_%h exp=%h", if1.out_ctrl, if1.out_data, e1);
          else n_pass++;
        end
      end
      if (flush1) q1.delete();
      else if (if1.in_valid && if1.in_ready) q1.push_back({if1.in_ctrl, if1.in_data});
    end
  end

  always @(negedge clk) begin
    if (clr) q0.delete();
    else begin
      if (if0.out_valid && if0.out_ready) begin
        n_chk++;
        if (q0.size() == 0) $display("FAIL sb0_unexpected got=%h_%h", if0.out_ctrl, if0.out_data);
        else begin
          e0 = q0.pop_front();
          if ({if0.out_ctrl, if0.out_data} !== e0) $display("FAIL sb0_order got=%h_%h exp=%h", if0.out_ctrl, if0.out_data, e0);
          else n_pass++;
        end
      end
      if (flush0) q0.delete();
      else if (if0.in_valid && if0.in_ready) q0.push_back({if0.in_ctrl, if0.in_data});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    else n_pass++;
  endtask

  task automatic idle();
    if1.in_valid = 0; if1.in_ctrl = '0; if1.in_data = '0; if1.out_ready = 0; flush1 = 0;
    if0.in_valid = 0; if0.in_ctrl = '0; if0.in_data = '0; if0.out_ready = 0; flush0 = 0;
  endtask

  task automatic do_reset();
    idle();
    clr = 1; step(); clr = 0;
  endtask

  task automatic test_reset();
    idle(); clr = 1; #1;
    chk("rst_ov1", 64'(if1.out_valid), 0);
    chk("rst_oc1", 64'(if1.out_ctrl), 0);
    chk("rst_od1", 64'(if1.out_data), 0);
    chk("rst_st1", 64'(stall1), 0);
    chk("rst_ir1", 64'(if1.in_ready), 1);
    chk("rst_ir0_ordy0", 64'(if0.in_ready), 1);
    if0.out_ready = 1; #1;
    chk("rst_ir0_ordy1", 64'(if0.in_ready), 1);
    chk("rst_st0", 64'(stall0), 0);
    step(); clr = 0;
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    if1.in_valid = 1; if1.in_ctrl = 32'h11; if1.in_data = 32'hA0; step();
    if1.in_ctrl = 32'h12; if1.in_data = 32'hB0; step();
    chk("mid_two_ir", 64'(if1.in_ready), 0);
    if1.in_valid = 0; #2;
    clr = 1; #1;
    chk("mid_ov", 64'(if1.out_valid), 0);
    chk("mid_oc", 64'(if1.out_ctrl), 0);
    chk("mid_od", 64'(if1.out_data), 0);
    chk("mid_ir", 64'(if1.in_ready), 1);
    step(); clr = 0; #1;
    chk("mid_st", 64'(stall1), 0);
    chk("mid_ir_rel", 64'(if1.in_ready), 1);
  endtask

  task automatic test_streaming();
    do_reset();
    if1.out_ready = 1; if1.in_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      if1.in_ctrl = 32'h100 + 32'(i); if1.in_data = 32'(i);
      step();
      chk("str_ov", 64'(if1.out_valid), 1);
      chk("str_od", 64'(if1.out_data), 64'(i));
      chk("str_ir", 64'(if1.in_ready), 1);
    end
    if1.in_valid = 0; step();
    chk("str_ov_end", 64'(if1.out_valid), 0);
    chk("str_st", 64'(stall1), 0);
  endtask

  task automatic test_back_to_back_noskid();
    do_reset();
    if0.out_ready = 1; if0.in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      if0.in_ctrl = $urandom | 32'h1; if0.in_data = $urandom;
      step();
      chk("b2b0_ov", 64'(if0.out_valid), 1);
      chk("b2b0_ir", 64'(if0.in_ready), 1);
    end
    if0.in_valid = 0; step();
    chk("b2b0_ov_end", 64'(if0.out_valid), 0);
    chk("b2b0_st", 64'(stall0), 0);
  endtask

  task automatic test_skid();
    do_reset();
    if1.in_valid = 1; if1.in_ctrl = 32'hA; if1.in_data = 32'hAAAA; step();
    chk("skid_ir_one", 64'(if1.in_ready), 1);
    if1.in_ctrl = 32'hB; if1.in_data = 32'hBBBB; step();
    chk("skid_ir_two", 64'(if1.in_ready), 0);
    chk("skid_od_a", 64'(if1.out_data), 64'hAAAA);
    chk("skid_st1", 64'(stall1), 1);
    if1.in_ctrl = 32'hC; if1.in_data = 32'hCCCC;
    step(); step();
    chk("skid_st3", 64'(stall1), 3);
    chk("skid_ir_hold", 64'(if1.in_ready), 0);
    if1.out_ready = 1; if1.in_valid = 0; step();
    chk("skid_od_b", 64'(if1.out_data), 64'hBBBB);
    chk("skid_oc_b", 64'(if1.out_ctrl), 64'hB);
    chk("skid_ir_rel", 64'(if1.in_ready), 1);
    step();
    chk("skid_ov_end", 64'(if1.out_valid), 0);
    chk("skid_oc_end", 64'(if1.out_ctrl), 0);
    chk("skid_st_end", 64'(stall1), 3);
  endtask

  task automatic test_flush();
    do_reset();
    if1.in_valid = 1; if1.in_ctrl = 32'hA; if1.in_data = 32'h1234; step();
    if1.in_ctrl = 32'hB; if1.in_data = 32'h5678; step();
    if1.in_ctrl = 32'hD; if1.in_data = 32'h9ABC; if1.out_ready = 1; flush1 = 1; step();
    chk("fl1_ov", 64'(if1.out_valid), 0);
    chk("fl1_oc", 64'(if1.out_ctrl), 0);
    chk("fl1_od_hold", 64'(if1.out_data), 64'h1234);
    chk("fl1_ir", 64'(if1.in_ready), 1);
    flush1 = 0; if1.in_valid = 0; step(); step();
    chk("fl1_skid_empty", 64'(if1.out_valid), 0);
    if0.in_valid = 1; if0.in_ctrl = 32'h77; if0.in_data = 32'hFEED; step();
    chk("fl0_ov_pre", 64'(if0.out_valid), 1);
    if0.in_valid = 0; flush0 = 1; step(); flush0 = 0;
    chk("fl0_ov", 64'(if0.out_valid), 0);
    chk("fl0_oc", 64'(if0.out_ctrl), 0);
    chk("fl0_od_zero", 64'(if0.out_data), 0);
  endtask

  task automatic test_bubble();
    do_reset();
    if1.out_ready = 1; if1.in_valid = 1; if1.in_ctrl = 32'h0000_00FF; if1.in_data = 32'h55;
    if0.out_ready = 1; if0.in_valid = 1; if0.in_ctrl = 32'h0000_00FF; if0.in_data = 32'h66;
    step();
    chk("bub1_oc", 64'(if1.out_ctrl), 64'hFF);
    if1.in_valid = 0; if0.in_valid = 0; step();
    chk("bub1_ov", 64'(if1.out_valid), 0);
    chk("bub1_oc0", 64'(if1.out_ctrl), 0);
    chk("bub1_od_hold", 64'(if1.out_data), 64'h55);
    chk("bub0_oc0", 64'(if0.out_ctrl), 0);
    chk("bub0_od_zero", 64'(if0.out_data), 0);
  endtask

  task automatic test_saturation();
    do_reset();
    if0.in_valid = 1; if0.in_ctrl = 32'h3; if0.in_data = 32'hCAFE; step();
    if0.in_valid = 0;
    chk("sat_ir_full", 64'(if0.in_ready), 0);
    if0.out_ready = 1; #1;
    chk("sat_ir_comb", 64'(if0.in_ready), 1);
    if0.out_ready = 0; #1;
    chk("sat_ir_comb0", 64'(if0.in_ready), 0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_15", 64'(stall0), 15);
    step();
    chk("sat_hold", 64'(stall0), 15);
    if0.out_ready = 1; step();
    chk("sat_ov_end", 64'(if0.out_valid), 0);
    chk("sat_after", 64'(stall0), 15);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; clr = 1;
    test_reset();
    test_reset_mid_stream();
    test_streaming();
    test_back_to_back_noskid();
    test_skid();
    test_flush();
    test_bubble();
    test_saturation();
    idle(); step(); step();
    chk("sb1_empty", 64'(q1.size()), 0);
    chk("sb0_empty", 64'(q0.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register that supersedes the fixed-field inter-stage latches of the five-stage MIPS core. It carries one control bundle and one data bundle per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) and adds a valid/ready handshake with an optional skid buffer. It also provides synchronous flush with bubble-to-NOP control clearing and a saturating stall-cycle counter. It sits between adjacent stage logic blocks and is instantiated once per boundary.

## Interface
Parameters:
- CTRL_W, 32, width of control bundle; all-zero encodes a NOP.
- DATA_W, 160, width of data bundle (PC+4, operands, immediate, instruction word, ...).
- SKID, 1, 1 = two-entry (main + skid) registered-ready stage; 0 = single entry, combinational ready.
- CLR_DATA, 0, 1 = flush/reset also zeroes data; 0 = data holds on flush.
- STALL_W, 16, width of stall counter.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  control bundle.
- in_data  in  DATA_W  data bundle.
- out_valid  out  1  main register holds a live entry.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  registered control; zero whenever out_valid=0.
- out_data  out  DATA_W  registered data.
- stall_cnt  out  STALL_W  saturating count of stall cycles.

## Operation
- Accept = in_valid & in_ready; drain = out_valid & out_ready.
- State (SKID=1): EMPTY (main and skid empty), ONE (main full), TWO (main and skid full). in_ready = (state != TWO), registered.
- EMPTY: accept -> main loads, ONE.
- ONE: accept & drain -> main reloads, stays ONE. Accept & !drain -> skid loads, TWO. !accept & drain -> main ctrl cleared, EMPTY. Neither -> hold.
- TWO: drain -> skid moves to main, ONE. Otherwise hold. in_ready=0, so no accept.
- SKID=0: single main register. in_ready = !out_valid | out_ready (combinational). Same load and drain rules; TWO is unreachable.
- Bubble rule: whenever main goes empty, out_ctrl is written 0 in that same edge. out_data holds, unless CLR_DATA=1, in which case it is zeroed.
- flush=1: on the next edge, state becomes EMPTY, out_valid=0, out_ctrl=0, skid cleared. Data is zeroed only if CLR_DATA=1.
- Flush priority: flush beats accept and drain in the same cycle. An entry accepted in the flush cycle is discarded. A drain in the flush cycle still completes downstream, because downstream sampled it.
- stall_cnt: increments when out_valid & !out_ready, saturating at all-ones. It is cleared only by clr; flush does not affect it.
- Entries are never duplicated, dropped (except by flush) or reordered.

## Timing
- Reset (clr=1, asynchronous): out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, state EMPTY. in_ready=1 for both SKID settings while out_ready is don't-care.
- Deassertion of clr is synchronised externally. The first accept can occur on the first edge after clr falls.
- Latency: accept at edge N gives out_valid=1 with that entry after edge N (visible in cycle N+1).
- Throughput: 1 entry/cycle with out_ready held high, for both SKID values.
- SKID=1: in_ready falls one cycle after the stall starts. The one in-flight entry lands in skid, so there is no combinational path from out_ready to in_ready.
- After a stall releases in TWO: skid entry presented the next cycle, in_ready=1 the same cycle.
- Counter at saturation with a stall present: value holds.

## Test plan
- Reset mid-stream: clr=1 asynchronously while in TWO -> outputs go to 0 immediately (before next edge); after release, in_ready=1 and stall_cnt=0.
- Streaming: out_ready=1, in_valid=1, in_data=1,2,3,4 on consecutive edges -> out_data=1,2,3,4 one cycle later, out_valid continuous, stall_cnt=0.
- Skid path (SKID=1): load A, hold out_ready=0 and present B -> B in skid and in_ready=0. Release after 3 cycles -> A then B out in order, stall_cnt=3, no entry lost.
- Flush priority: in TWO with in_valid=1, assert flush for 1 cycle -> out_valid=0 and out_ctrl=0 next cycle, skid empty, offered entry discarded. out_data holds for CLR_DATA=0 and is zero for CLR_DATA=1.
- Bubble: single entry ctrl=0x0000_00FF drained with in_valid=0 -> next cycle out_valid=0, out_ctrl=0.
- SKID=0 and saturation: with STALL_W=4, stall 20 cycles -> stall_cnt=15 and held. in_ready tracks out_ready combinationally while full.
